regbank_arbiter: RTL and testbench
==================================

# regbank_arbiter

Arbitrates the single write port of the 4-entry × 4-bit register bank between the core control FSM's writeback path and a debug/loader host. Each write is a req/ack transaction. Simultaneous requests are granted round-robin, and the debug host can lock out core writes. The block sits between the core FSM (`ena_wr`/`wr_ack`), the debug port, and the register bank write pins. It replaces the direct `ena_wr` → bank connection.

## Interface
- `WR_CYCLES`, default 1: number of cycles `rf_we` is held per write; legal range 1–15.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `core_req` in 1: core write request; driven from the FSM's `ena_wr`.
- `core_addr` in 2: core target register; R0 or Rd, already muxed.
- `core_data` in 4: core write data; LDR immediate or ULA result.
- `core_ack` out 1: one-cycle completion pulse to the core; drives the FSM's `wr_ack`.
- `dbg_req` in 1: debug write request.
- `dbg_addr` in 2: debug target register.
- `dbg_data` in 4: debug write data.
- `dbg_lock` in 1: while 1, `core_req` is masked and never granted.
- `dbg_ack` out 1: one-cycle completion pulse to the debug host.
- `rf_we` out 1: register bank write enable.
- `rf_addr` out 2: register bank write address.
- `rf_data` out 4: register bank write data.
- `busy` out 1: 1 in any state other than IDLE.
- `state_out` out 2: current state encoding, for debug/LEDs.
- `conflicts` out 4: saturating count of arbitration conflicts.

## Operation
- **States:** IDLE=0, WRITE=1, ACK=2. Encoding 3 is illegal and returns to IDLE on the next edge.
- **Effective core request:** `creq = core_req & ~dbg_lock`.
- **IDLE**
  - If neither `creq` nor `dbg_req` is set: stay in IDLE.
  - If exactly one is set: grant that requester.
  - If both are set: grant the requester that was not granted last (`last_grant` bit), and increment `conflicts` (saturates at 15).
  - On a grant: latch owner, addr and data into internal registers; load the cycle counter with `WR_CYCLES`; go to WRITE.
- **WRITE**
  - `rf_we`=1, with `rf_addr`/`rf_data` taken from the latched values.
  - Later changes on the request inputs are ignored.
  - The counter decrements each cycle; at count 1, go to ACK.
- **ACK**
  - `rf_we`=0.
  - The owner's ack is 1; the other ack is 0.
  - `last_grant` ← owner.
  - Go to IDLE.
- **Requester rules:**
  - A requester holds req, addr and data stable from assertion until it samples ack=1.
  - It drops req on that same edge, which the core FSM does by leaving its WB/LDR state.
  - A requester still high in the IDLE cycle after its ack is treated as a new request.
- **Lock timing:** `dbg_lock` rising while a core write is in WRITE/ACK does not abort it; the lock only affects IDLE grant decisions.
- **Register bank port:** `rf_addr`/`rf_data` hold their last latched values outside WRITE, and are 0 after reset.

## Timing
- **Registered outputs:** all outputs are registered and decoded from state plus latched registers; there is no combinational path from inputs to outputs.
- **Reset:**
  - `rst`=0 at an edge forces state IDLE and sets `rf_we`, `rf_addr`, `rf_data`, `core_ack`, `dbg_ack`, `busy`, `state_out` and `conflicts` to 0.
  - `last_grant` resets to debug, so the core wins the first conflict.
  - Reset mid-WRITE abandons the write: `rf_we` is low from the next cycle and no ack is issued.
- **Latency:**
  - Request sampled in IDLE at edge E.
  - `rf_we` high for cycles E+1 … E+`WR_CYCLES`.
  - Ack high in cycle E+`WR_CYCLES`+1.
  - IDLE at E+`WR_CYCLES`+2.
- **Throughput:** back-to-back transactions take `WR_CYCLES`+2 cycles each. With both requesters held high, grants alternate core, dbg, core, …
- **Acks:** each ack is exactly one cycle wide. `core_ack` and `dbg_ack` are never high together.

## Test plan
- **Core-only write:** reset, then `core_req`=1, addr=2, data=4'hA with `WR_CYCLES`=1 → `rf_we`=1 with `rf_addr`=2, `rf_data`=A for 1 cycle; `core_ack` pulses the next cycle; `busy` is 1 for 2 cycles.
- **Conflict and round-robin:** both requesters held high with `WR_CYCLES`=2 (core addr 0/data 3, dbg addr 1/data C) → grant order core, dbg, core. Each `rf_we` window is 2 cycles. `conflicts` increments once per IDLE conflict.
- **Lock:** `dbg_lock`=1 with `core_req`=1 held → no `rf_we` and no `core_ack` for 20 cycles. Releasing the lock → core write completes 2 cycles later.
- **Input stability in WRITE:** `core_data` changes to 5 during WRITE (original value 9) → `rf_data` stays 9 throughout the write.
- **Reset mid-WRITE:** `WR_CYCLES`=4, reset asserted in the 2nd WRITE cycle → `rf_we`=0 and all outputs 0 on the next cycle; no ack ever issues.
- **Saturation:** force 20 conflicts → `conflicts` reaches 15 and holds.

Source files
------------

// File: rtl/regbank_arbiter.sv
// regbank_arbiter
//   Shares the single write port of the 4 x 4-bit register bank between the
//   core control FSM writeback path and a debug/loader host. Each write is a
//   req/ack handshake; simultaneous requests alternate round-robin, and the
//   debug host can lock core writes out of the grant decision.
//
// State table
//   state | meaning
//   IDLE  | waiting for a request; grant decision made here
//   WRITE | rf_we held for WR_CYCLES cycles with latched addr/data
//   ACK   | one-cycle ack pulse to the owner, then back to IDLE
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset
//   core_req   : core write request (FSM ena_wr)
//   core_addr  : core target register
//   core_data  : core write data
//   core_ack   : one-cycle completion pulse to the core (FSM wr_ack)
//   dbg_req    : debug write request
//   dbg_addr   : debug target register
//   dbg_data   : debug write data
//   dbg_lock   : masks core_req from grant decisions while high
//   dbg_ack    : one-cycle completion pulse to the debug host
//   rf_we      : register bank write enable
//   rf_addr    : register bank write address
//   rf_data    : register bank write data
//   busy       : high in any state other than IDLE
//   state_out  : current state encoding
//   conflicts  : saturating count of IDLE arbitration conflicts
module regbank_arbiter #(
  parameter int unsigned WR_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       core_req,
  input  logic [1:0] core_addr,
  input  logic [3:0] core_data,
  output logic       core_ack,
  input  logic       dbg_req,
  input  logic [1:0] dbg_addr,
  input  logic [3:0] dbg_data,
  input  logic       dbg_lock,
  output logic       dbg_ack,
  output logic       rf_we,
  output logic [1:0] rf_addr,
  output logic [3:0] rf_data,
  output logic       busy,
  output logic [1:0] state_out,
  output logic [3:0] conflicts
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WR_CYCLES);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic       owner_q;       // 1 = core owns the current write, 0 = debug
  logic       last_grant_q;  // 1 = core was granted last, 0 = debug
  logic [1:0] addr_q;
  logic [3:0] data_q;
  logic [3:0] conflicts_q;

  logic creq_d;
  logic grant_d;
  logic grant_core_d;
  logic conflict_d;

  always_comb begin
    creq_d       = core_req & ~dbg_lock;
    grant_d      = creq_d | dbg_req;
    conflict_d   = creq_d & dbg_req;
    // On a conflict the core wins only if debug had the previous grant.
    grant_core_d = creq_d & (~dbg_req | ~last_grant_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      conflicts_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            owner_q <= grant_core_d;
            addr_q  <= grant_core_d ? core_addr : dbg_addr;
            data_q  <= grant_core_d ? core_data : dbg_data;
            cnt_q   <= CNT_LOAD;
            state_q <= WRITE;
            if (conflict_d && conflicts_q != 4'hF) begin
              conflicts_q <= conflicts_q + 4'd1;
            end
          end
        end
        WRITE: begin
          if (cnt_q <= 4'd1) begin
            state_q <= ACK;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ACK: begin
          last_grant_q <= owner_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Every output is a decode of registered state, so nothing is combinational
  // from the request inputs.
  assign rf_we     = (state_q == WRITE);
  assign rf_addr   = addr_q;
  assign rf_data   = data_q;
  assign core_ack  = (state_q == ACK) &  owner_q;
  assign dbg_ack   = (state_q == ACK) & ~owner_q;
  assign busy      = (state_q != IDLE);
  assign state_out = state_q;
  assign conflicts = conflicts_q;

endmodule

// File: tb/tb_regbank_arbiter.sv
module tb_regbank_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       core_req;
  logic [1:0] core_addr;
  logic [3:0] core_data;
  logic       dbg_req;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;
  logic       dbg_lock;

  // Instance 0: WR_CYCLES=1, instance 1: WR_CYCLES=2, instance 2: WR_CYCLES=4
  logic       core_ack  [3];
  logic       dbg_ack   [3];
  logic       rf_we     [3];
  logic [1:0] rf_addr   [3];
  logic [3:0] rf_data   [3];
  logic       busy      [3];
  logic [1:0] state_out [3];
  logic [3:0] conflicts [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regbank_arbiter #(.WR_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_addr(core_addr), .core_data(core_data), .core_ack(core_ack[0]),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_lock(dbg_lock), .dbg_ack(dbg_ack[0]),
    .rf_we(rf_we[0]), .rf_addr(rf_addr[0]), .rf_data(rf_data[0]),
    .busy(busy[0]), .state_out(state_out[0]), .conflicts(conflicts[0])
  );

  regbank_arbiter #(.WR_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_addr(core_addr), .core_data(core_data), .core_ack(core_ack[1]),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_lock(dbg_lock), .dbg_ack(dbg_ack[1]),
    .rf_we(rf_we[1]), .rf_addr(rf_addr[1]), .rf_data(rf_data[1]),
    .busy(busy[1]), .state_out(state_out[1]), .conflicts(conflicts[1])
  );

  regbank_arbiter #(.WR_CYCLES(4)) u_w4 (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_addr(core_addr), .core_data(core_data), .core_ack(core_ack[2]),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_lock(dbg_lock), .dbg_ack(dbg_ack[2]),
    .rf_we(rf_we[2]), .rf_addr(rf_addr[2]), .rf_data(rf_data[2]),
    .busy(busy[2]), .state_out(state_out[2]), .conflicts(conflicts[2])
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    core_req  = 1'b0;
    core_addr = '0;
    core_data = '0;
    dbg_req   = 1'b0;
    dbg_addr  = '0;
    dbg_data  = '0;
    dbg_lock  = 1'b0;
  endtask

  // Holds reset for two edges and releases it; the next edge is the first
  // one sampled out of reset.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag, input int k);
    chk({tag, " rf_we"},     int'(rf_we[k]),     0);
    chk({tag, " rf_addr"},   int'(rf_addr[k]),   0);
    chk({tag, " rf_data"},   int'(rf_data[k]),   0);
    chk({tag, " core_ack"},  int'(core_ack[k]),  0);
    chk({tag, " dbg_ack"},   int'(dbg_ack[k]),   0);
    chk({tag, " busy"},      int'(busy[k]),      0);
    chk({tag, " state_out"}, int'(state_out[k]), 0);
    chk({tag, " conflicts"}, int'(conflicts[k]), 0);
  endtask

  initial begin
    int seen;
    int both_ack;
    logic       exp_core [3];
    logic [1:0] exp_addr [3];
    logic [3:0] exp_data [3];

    clear_inputs();
    rst = 1'b0;

    // Reset state on every instance
    do_reset();
    for (int k = 0; k < 3; k++) chk_all_zero($sformatf("reset%0d", k), k);

    // Core-only write, WR_CYCLES=1
    core_req = 1'b1; core_addr = 2'd2; core_data = 4'hA;
    tick();
    chk("core1 rf_we",   int'(rf_we[0]),     1);
    chk("core1 rf_addr", int'(rf_addr[0]),   2);
    chk("core1 rf_data", int'(rf_data[0]),   10);
    chk("core1 busy",    int'(busy[0]),      1);
    chk("core1 state",   int'(state_out[0]), 1);
    chk("core1 ack_early", int'(core_ack[0]), 0);
    tick();
    chk("core1 rf_we_off", int'(rf_we[0]),     0);
    chk("core1 core_ack",  int'(core_ack[0]),  1);
    chk("core1 dbg_ack",   int'(dbg_ack[0]),   0);
    chk("core1 busy2",     int'(busy[0]),      1);
    chk("core1 state2",    int'(state_out[0]), 2);
    core_req = 1'b0;
    tick();
    chk("core1 ack_once", int'(core_ack[0]),  0);
    chk("core1 idle",     int'(busy[0]),      0);
    chk("core1 state3",   int'(state_out[0]), 0);
    chk("core1 hold_addr", int'(rf_addr[0]),  2);
    chk("core1 hold_data", int'(rf_data[0]),  10);

    // Conflict and round-robin, WR_CYCLES=2: core, dbg, core
    do_reset();
    core_req = 1'b1; core_addr = 2'd0; core_data = 4'h3;
    dbg_req  = 1'b1; dbg_addr  = 2'd1; dbg_data  = 4'hC;
    exp_core[0] = 1'b1; exp_addr[0] = 2'd0; exp_data[0] = 4'h3;
    exp_core[1] = 1'b0; exp_addr[1] = 2'd1; exp_data[1] = 4'hC;
    exp_core[2] = 1'b1; exp_addr[2] = 2'd0; exp_data[2] = 4'h3;
    for (int g = 0; g < 3; g++) begin
      tick();
      chk($sformatf("rr%0d we1", g),   int'(rf_we[1]),     1);
      chk($sformatf("rr%0d addr", g),  int'(rf_addr[1]),   int'(exp_addr[g]));
      chk($sformatf("rr%0d data", g),  int'(rf_data[1]),   int'(exp_data[g]));
      chk($sformatf("rr%0d confl", g), int'(conflicts[1]), g + 1);
      tick();
      chk($sformatf("rr%0d we2", g),   int'(rf_we[1]),     1);
      tick();
      chk($sformatf("rr%0d we_off", g),   int'(rf_we[1]),    0);
      chk($sformatf("rr%0d core_ack", g), int'(core_ack[1]), int'(exp_core[g]));
      chk($sformatf("rr%0d dbg_ack", g),  int'(dbg_ack[1]),  int'(!exp_core[g]));
      tick();
      chk($sformatf("rr%0d idle", g),  int'(busy[1]),      0);
    end

    // Lock holds off the core for 20 cycles; release completes 2 cycles later
    do_reset();
    dbg_lock = 1'b1;
    core_req = 1'b1; core_addr = 2'd1; core_data = 4'h6;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rf_we[0] || core_ack[0] || busy[0]) seen++;
    end
    chk("lock no_activity", seen, 0);
    dbg_lock = 1'b0;
    tick();
    chk("lock rf_we",   int'(rf_we[0]),   1);
    chk("lock rf_addr", int'(rf_addr[0]), 1);
    chk("lock rf_data", int'(rf_data[0]), 6);
    tick();
    chk("lock core_ack", int'(core_ack[0]), 1);
    core_req = 1'b0;

    // Input stability during WRITE, WR_CYCLES=2
    do_reset();
    core_req = 1'b1; core_addr = 2'd3; core_data = 4'h9;
    tick();
    chk("stab data1", int'(rf_data[1]), 9);
    core_data = 4'h5;
    tick();
    chk("stab we2",   int'(rf_we[1]),   1);
    chk("stab data2", int'(rf_data[1]), 9);
    tick();
    chk("stab ack",   int'(core_ack[1]), 1);
    chk("stab data3", int'(rf_data[1]),  9);
    core_req = 1'b0;

    // Reset in the 2nd WRITE cycle, WR_CYCLES=4
    do_reset();
    core_req = 1'b1; core_addr = 2'd2; core_data = 4'h7;
    tick();
    chk("rstmid we1", int'(rf_we[2]), 1);
    tick();
    chk("rstmid we2", int'(rf_we[2]), 1);
    rst = 1'b0;
    tick();
    chk_all_zero("rstmid", 2);
    rst = 1'b1;
    core_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (core_ack[2] || dbg_ack[2] || rf_we[2]) seen++;
    end
    chk("rstmid no_ack", seen, 0);

    // Conflict saturation, WR_CYCLES=1: one conflict every 3 cycles
    do_reset();
    core_req = 1'b1; core_addr = 2'd1; core_data = 4'h2;
    dbg_req  = 1'b1; dbg_addr  = 2'd3; dbg_data  = 4'h8;
    both_ack = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (core_ack[0] && dbg_ack[0]) both_ack++;
    end
    chk("sat after5", int'(conflicts[0]), 5);
    for (int i = 0; i < 55; i++) begin
      tick();
      if (core_ack[0] && dbg_ack[0]) both_ack++;
    end
    chk("sat final", int'(conflicts[0]), 15);
    chk("sat acks_exclusive", both_ack, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
